// File: rtl/axi_lite_2to1_arbiter.sv
// Two-requester AXI-Lite arbiter in front of a single master port.
// Read and write paths each run their own small FSM with round-robin
// grant and one outstanding transaction. Requester-side readies depend
// only on registered state and requester valids, so there is no
// combinational path from the master-side readies back to the requesters.
`timescale 1ns/1ps

module axi_lite_2to1_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    // requester 0: read
    input  logic                      s0_arvalid,
    input  logic [ADDR_WIDTH-1:0]     s0_araddr,
    output logic                      s0_arready,
    output logic                      s0_rvalid,
    output logic [DATA_WIDTH-1:0]     s0_rdata,
    output logic [1:0]                s0_rresp,
    input  logic                      s0_rready,
    // requester 0: write
    input  logic                      s0_awvalid,
    input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
    output logic                      s0_awready,
    input  logic                      s0_wvalid,
    input  logic [DATA_WIDTH-1:0]     s0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
    output logic                      s0_wready,
    output logic                      s0_bvalid,
    output logic [1:0]                s0_bresp,
    input  logic                      s0_bready,

    // requester 1: read
    input  logic                      s1_arvalid,
    input  logic [ADDR_WIDTH-1:0]     s1_araddr,
    output logic                      s1_arready,
    output logic                      s1_rvalid,
    output logic [DATA_WIDTH-1:0]     s1_rdata,
    output logic [1:0]                s1_rresp,
    input  logic                      s1_rready,
    // requester 1: write
    input  logic                      s1_awvalid,
    input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
    output logic                      s1_awready,
    input  logic                      s1_wvalid,
    input  logic [DATA_WIDTH-1:0]     s1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
    output logic                      s1_wready,
    output logic                      s1_bvalid,
    output logic [1:0]                s1_bresp,
    input  logic                      s1_bready,

    // master port
    output logic                      m_arvalid,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    input  logic                      m_arready,
    input  logic                      m_rvalid,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    output logic                      m_rready,
    output logic                      m_awvalid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,

    // current owner per path, one-hot, 00 when idle
    output logic [1:0]                rd_grant,
    output logic [1:0]                wr_grant
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;

    rd_state_t rd_state;
    wr_state_t wr_state;

    // index of the previous winner (0 = s0, 1 = s1); reset to 1 so s0 wins first
    logic last_rd;
    logic last_wr;
    logic aw_done;
    logic w_done;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic rd_req_any;
    logic rd_win;
    logic rd_accept;
    logic rd_data_phase;

    // Round-robin pick among requesters presenting a read address
    always_comb begin
        rd_req_any = s0_arvalid | s1_arvalid;
        if (s0_arvalid && s1_arvalid) rd_win = ~last_rd;
        else                          rd_win = s1_arvalid;
    end

    assign rd_accept     = (rd_state == R_IDLE) && rd_req_any;
    assign s0_arready    = rd_accept && !rd_win;
    assign s1_arready    = rd_accept &&  rd_win;
    assign rd_data_phase = (rd_state == R_DATA);

    // Read data is steered only to the current owner; the other side sees zeros
    always_comb begin
        s0_rvalid = 1'b0;
        s0_rdata  = '0;
        s0_rresp  = 2'b00;
        s1_rvalid = 1'b0;
        s1_rdata  = '0;
        s1_rresp  = 2'b00;
        m_rready  = 1'b0;
        if (rd_data_phase) begin
            if (rd_grant[1]) begin
                s1_rvalid = m_rvalid;
                s1_rdata  = m_rdata;
                s1_rresp  = m_rresp;
                m_rready  = s1_rready;
            end else begin
                s0_rvalid = m_rvalid;
                s0_rdata  = m_rdata;
                s0_rresp  = m_rresp;
                m_rready  = s0_rready;
            end
        end
    end

    // Read FSM: accept address, issue it downstream, then relay the data beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            rd_grant  <= 2'b00;
            last_rd   <= 1'b1;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_accept) begin
                        m_araddr  <= rd_win ? s1_araddr : s0_araddr;
                        rd_grant  <= rd_win ? 2'b10 : 2'b01;
                        last_rd   <= rd_win;
                        m_arvalid <= 1'b1;
                        rd_state  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        rd_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_rvalid && m_rready) begin
                        rd_grant <= 2'b00;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic wr_cand0;
    logic wr_cand1;
    logic wr_win;
    logic wr_accept;
    logic wr_resp_phase;
    logic aw_hs;
    logic w_hs;

    // A requester competes only once both its address and data are valid
    always_comb begin
        wr_cand0 = s0_awvalid && s0_wvalid;
        wr_cand1 = s1_awvalid && s1_wvalid;
        if (wr_cand0 && wr_cand1) wr_win = ~last_wr;
        else                      wr_win = wr_cand1;
    end

    assign wr_accept     = (wr_state == W_IDLE) && (wr_cand0 || wr_cand1);
    assign s0_awready    = wr_accept && !wr_win;
    assign s0_wready     = wr_accept && !wr_win;
    assign s1_awready    = wr_accept &&  wr_win;
    assign s1_wready     = wr_accept &&  wr_win;
    assign wr_resp_phase = (wr_state == W_RESP);
    assign aw_hs         = m_awvalid && m_awready;
    assign w_hs          = m_wvalid && m_wready;

    // Write response is steered only to the current owner
    always_comb begin
        s0_bvalid = 1'b0;
        s0_bresp  = 2'b00;
        s1_bvalid = 1'b0;
        s1_bresp  = 2'b00;
        m_bready  = 1'b0;
        if (wr_resp_phase) begin
            if (wr_grant[1]) begin
                s1_bvalid = m_bvalid;
                s1_bresp  = m_bresp;
                m_bready  = s1_bready;
            end else begin
                s0_bvalid = m_bvalid;
                s0_bresp  = m_bresp;
                m_bready  = s0_bready;
            end
        end
    end

    // Write FSM: AW and W are issued together but may complete independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= W_IDLE;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_wvalid  <= 1'b0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wr_grant  <= 2'b00;
            last_wr   <= 1'b1;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_accept) begin
                        m_awaddr  <= wr_win ? s1_awaddr : s0_awaddr;
                        m_wdata   <= wr_win ? s1_wdata  : s0_wdata;
                        m_wstrb   <= wr_win ? s1_wstrb  : s0_wstrb;
                        wr_grant  <= wr_win ? 2'b10 : 2'b01;
                        last_wr   <= wr_win;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        wr_state  <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    // leave as soon as the last outstanding handshake lands
                    if ((aw_done || aw_hs) && (w_done || w_hs))
                        wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (m_bvalid && m_bready) begin
                        wr_grant <= 2'b00;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_2to1_arbiter.sv
// Bench for axi_lite_2to1_arbiter: arbitration vector table, directed
// multi-cycle sequences, then randomized traffic against a
// transaction-level model of both requesters and the downstream slave.
`timescale 1ns/1ps

module tb_axi_lite_2to1_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // requester-side drives and observations, index 0 = s0, 1 = s1
    logic [1:0]  ar_v, aw_v, w_v, r_rdy, b_rdy;
    logic [31:0] ar_a [2];
    logic [31:0] aw_a [2];
    logic [31:0] w_d  [2];
    logic [3:0]  w_s  [2];
    logic [1:0]  arr, awr, wr, rv, bv;
    logic [31:0] s_rdata [2];
    logic [1:0]  s_rresp [2];
    logic [1:0]  s_bresp [2];

    // master side
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;
    logic [1:0]  rd_grant, wr_grant;

    axi_lite_2to1_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_arvalid(ar_v[0]), .s0_araddr(ar_a[0]), .s0_arready(arr[0]),
        .s0_rvalid(rv[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rready(r_rdy[0]),
        .s0_awvalid(aw_v[0]), .s0_awaddr(aw_a[0]), .s0_awready(awr[0]),
        .s0_wvalid(w_v[0]), .s0_wdata(w_d[0]), .s0_wstrb(w_s[0]), .s0_wready(wr[0]),
        .s0_bvalid(bv[0]), .s0_bresp(s_bresp[0]), .s0_bready(b_rdy[0]),
        .s1_arvalid(ar_v[1]), .s1_araddr(ar_a[1]), .s1_arready(arr[1]),
        .s1_rvalid(rv[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rready(r_rdy[1]),
        .s1_awvalid(aw_v[1]), .s1_awaddr(aw_a[1]), .s1_awready(awr[1]),
        .s1_wvalid(w_v[1]), .s1_wdata(w_d[1]), .s1_wstrb(w_s[1]), .s1_wready(wr[1]),
        .s1_bvalid(bv[1]), .s1_bresp(s_bresp[1]), .s1_bready(b_rdy[1]),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        ar_v = '0; aw_v = '0; w_v = '0; r_rdy = '0; b_rdy = '0;
        for (int i = 0; i < 2; i++) begin
            ar_a[i] = '0; aw_a[i] = '0; w_d[i] = '0; w_s[i] = '0;
        end
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // round-robin rule: on a tie the previous winner yields
    function automatic int pick(input logic [1:0] req, input int last);
        if (req == 2'b11) return 1 - last;
        return req[1] ? 1 : 0;
    endfunction

    // idle-state arbitration vectors
    // stim: {s0_ar, s1_ar, s0_aw, s0_w, s1_aw, s1_w}
    // exp : {arready0, arready1, awready0, wready0, awready1, wready1}
    typedef struct {
        logic [5:0] stim;
        logic [5:0] exp;
    } vec_t;
    vec_t vt [10];

    // reference model state
    bit          rbusy, rsent, wbusy, aw_sent, w_sent;
    int          rown, rlast, wown, wlast, rw, ww;
    logic [31:0] raddr_exp, waddr_exp, wdata_exp;
    logic [3:0]  wstrb_exp;
    bit          s_rpend, s_bpend, r_drop, b_drop;
    int          s_rdly, s_bdly, rcnt, wcnt;
    logic [1:0]  ar_take, aw_take, exp2, expw;
    logic        erv, ebv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr();
        vt[0] = '{6'b000000, 6'b000000};
        vt[1] = '{6'b100000, 6'b100000};
        vt[2] = '{6'b010000, 6'b010000};
        vt[3] = '{6'b110000, 6'b100000};
        vt[4] = '{6'b001000, 6'b000000};
        vt[5] = '{6'b001100, 6'b001100};
        vt[6] = '{6'b001011, 6'b000011};
        vt[7] = '{6'b001111, 6'b001100};
        vt[8] = '{6'b000001, 6'b000000};
        vt[9] = '{6'b110111, 6'b100011};
        do_reset();

        // reset state
        @(negedge clk); #1;
        chk("rst_grants", 32'({rd_grant, wr_grant}), 32'd0);
        chk("rst_m_valids", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'd0);
        chk("rst_m_regs", m_araddr | m_awaddr | m_wdata | 32'(m_wstrb), 32'd0);

        // vectors applied and withdrawn between edges: FSMs stay idle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ar_v[0] = vt[k].stim[5]; ar_v[1] = vt[k].stim[4];
            aw_v[0] = vt[k].stim[3]; w_v[0]  = vt[k].stim[2];
            aw_v[1] = vt[k].stim[1]; w_v[1]  = vt[k].stim[0];
            #1;
            chk($sformatf("vec%0d_readies", k),
                32'({arr[0], arr[1], awr[0], wr[0], awr[1], wr[1]}), 32'(vt[k].exp));
            #1; clr();
        end

        // A: single s0 read, minimum latency
        @(negedge clk); ar_v[0] = 1'b1; ar_a[0] = 32'h8000_0010; m_arready = 1'b1; #1;
        chk("A_arready", 32'(arr), 32'd1);
        chk("A_grant_c0", 32'(rd_grant), 32'd0);
        @(negedge clk); ar_v[0] = 1'b0; ar_v[1] = 1'b1; #1;
        chk("A_m_arvalid", 32'(m_arvalid), 32'd1);
        chk("A_m_araddr", m_araddr, 32'h8000_0010);
        chk("A_grant_c1", 32'(rd_grant), 32'd1);
        chk("A_no_ready_busy", 32'(arr), 32'd0);
        @(negedge clk); ar_v[1] = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00; r_rdy[0] = 1'b1; #1;
        chk("A_rvalid", 32'(rv), 32'd1);
        chk("A_rdata", s_rdata[0], 32'hDEAD_BEEF);
        chk("A_rresp", 32'(s_rresp[0]), 32'd0);
        chk("A_m_rready", 32'(m_rready), 32'd1);
        @(negedge clk); clr(); #1;
        chk("A_grant_c3", 32'(rd_grant), 32'd0);

        // B: s1 write, W accepted three cycles before AW
        @(negedge clk); aw_v[1] = 1'b1; w_v[1] = 1'b1;
        aw_a[1] = 32'h1000_0000; w_d[1] = 32'h0000_00A5; w_s[1] = 4'h1; #1;
        chk("B_ready", 32'({awr, wr}), 32'b1010);
        @(negedge clk); aw_v[1] = 1'b0; w_v[1] = 1'b0; m_wready = 1'b1; b_rdy[1] = 1'b1; #1;
        chk("B_m_valids", 32'({m_awvalid, m_wvalid}), 32'b11);
        chk("B_m_fields", m_awaddr ^ m_wdata ^ 32'(m_wstrb), 32'h1000_00A4);
        chk("B_wr_grant", 32'(wr_grant), 32'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); m_wready = 1'b0; #1;
            chk("B_wait_aw", 32'({m_awvalid, m_wvalid, m_bready}), 32'b100);
        end
        @(negedge clk); m_awready = 1'b1; #1;
        chk("B_aw_last", 32'({m_awvalid, m_wvalid, m_bready}), 32'b100);
        @(negedge clk); m_awready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00; #1;
        chk("B_resp", 32'({m_awvalid, bv, m_bready}), 32'b0101);
        chk("B_bresp", 32'(s_bresp[1]), 32'd0);
        @(negedge clk); clr(); #1;
        chk("B_done", 32'(wr_grant), 32'd0);

        // C: s0 write concurrent with s1 read
        @(negedge clk); ar_v[1] = 1'b1; ar_a[1] = 32'h2000_0040;
        aw_v[0] = 1'b1; w_v[0] = 1'b1; aw_a[0] = 32'h3000_0000; w_d[0] = 32'h1234_5678; w_s[0] = 4'hF; #1;
        chk("C_ready", 32'({arr, awr}), 32'b1001);
        @(negedge clk); clr(); m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        r_rdy[1] = 1'b1; b_rdy[0] = 1'b1; #1;
        chk("C_grants", 32'({rd_grant, wr_grant}), 32'b1001);
        chk("C_m_valids", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'b111);
        chk("C_m_araddr", m_araddr, 32'h2000_0040);
        @(negedge clk); m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b10; m_bvalid = 1'b1; m_bresp = 2'b01; #1;
        chk("C_rv_bv", 32'({rv, bv}), 32'b1001);
        chk("C_rdata", s_rdata[1], 32'hCAFE_F00D);
        chk("C_resps", 32'({s_rresp[1], s_bresp[0]}), 32'b1001);
        @(negedge clk); clr(); #1;
        chk("C_done", 32'({rd_grant, wr_grant}), 32'd0);

        // D: s0 holds AW without W while s1 presents a full write
        @(negedge clk); aw_v[0] = 1'b1; aw_a[0] = 32'h0000_0004;
        aw_v[1] = 1'b1; w_v[1] = 1'b1; aw_a[1] = 32'h0000_0008; w_d[1] = 32'h77; w_s[1] = 4'h3; #1;
        chk("D_s1_first", 32'({awr, wr}), 32'b1010);
        @(negedge clk); aw_v[1] = 1'b0; w_v[1] = 1'b0; m_awready = 1'b1; m_wready = 1'b1; b_rdy[1] = 1'b1; #1;
        chk("D_busy", 32'(awr), 32'd0);
        @(negedge clk); m_bvalid = 1'b1; #1;
        chk("D_bvalid", 32'(bv), 32'd2);
        @(negedge clk); m_bvalid = 1'b0; #1;
        chk("D_idle_no_w", 32'({awr, wr_grant}), 32'd0);
        @(negedge clk); w_v[0] = 1'b1; w_d[0] = 32'h99; w_s[0] = 4'h8; #1;
        chk("D_s0_now", 32'({awr, wr}), 32'b0101);

        // E: async reset while an AR is outstanding, then contested read
        @(negedge clk); clr(); ar_v[0] = 1'b1; ar_a[0] = 32'h55; #1;
        chk("E_accept", 32'(arr), 32'd1);
        @(negedge clk); ar_v[0] = 1'b0; #1;
        chk("E_m_arvalid", 32'(m_arvalid), 32'd1);
        #2; rst_n = 1'b0; #1;
        chk("E_async_clear", 32'({m_arvalid, rd_grant}), 32'd0);
        @(negedge clk); rst_n = 1'b1; ar_v = 2'b11; ar_a[0] = 32'h100; ar_a[1] = 32'h200; #1;
        chk("E_s0_first", 32'(arr), 32'd1);

        // R: randomized traffic against the transaction model
        do_reset();
        rbusy = 0; rsent = 0; rlast = 1; wbusy = 0; aw_sent = 0; w_sent = 0; wlast = 1;
        rown = 0; wown = 0; s_rpend = 0; s_bpend = 0; r_drop = 0; b_drop = 0;
        s_rdly = 0; s_bdly = 0; rcnt = 0; wcnt = 0; ar_take = '0; aw_take = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ar_v = ar_v & ~ar_take; aw_v = aw_v & ~aw_take; w_v = w_v & ~aw_take;
            ar_take = '0; aw_take = '0;
            if (r_drop) m_rvalid = 1'b0;
            if (b_drop) m_bvalid = 1'b0;
            r_drop = 0; b_drop = 0;
            for (int i = 0; i < 2; i++) begin
                if (!ar_v[i] && $urandom_range(0, 2) == 0) begin ar_v[i] = 1'b1; ar_a[i] = $urandom; end
                if (!aw_v[i] && $urandom_range(0, 3) == 0) begin aw_v[i] = 1'b1; aw_a[i] = $urandom; end
                if (!w_v[i] && $urandom_range(0, 3) == 0) begin
                    w_v[i] = 1'b1; w_d[i] = $urandom; w_s[i] = 4'($urandom);
                end
                r_rdy[i] = 1'($urandom); b_rdy[i] = 1'($urandom);
            end
            m_arready = 1'($urandom); m_awready = 1'($urandom); m_wready = 1'($urandom);
            if (s_rpend) begin
                if (s_rdly == 0) begin
                    m_rvalid = 1'b1; m_rdata = $urandom; m_rresp = 2'($urandom); s_rpend = 0;
                end else s_rdly--;
            end
            if (s_bpend) begin
                if (s_bdly == 0) begin
                    m_bvalid = 1'b1; m_bresp = 2'($urandom); s_bpend = 0;
                end else s_bdly--;
            end
            #1;
            // read path expectations
            exp2 = '0; rw = 0;
            if (!rbusy && ar_v != 2'b00) begin
                rw = pick(ar_v, rlast);
                exp2 = (rw == 1) ? 2'b10 : 2'b01;
            end
            chk("R_arready", 32'(arr), 32'(exp2));
            chk("R_rd_grant", 32'(rd_grant), rbusy ? ((rown == 1) ? 32'd2 : 32'd1) : 32'd0);
            chk("R_m_arvalid", 32'(m_arvalid), 32'(rbusy && !rsent));
            if (rbusy && !rsent) chk("R_m_araddr", m_araddr, raddr_exp);
            for (int i = 0; i < 2; i++) begin
                erv = rbusy && rsent && (rown == i) && m_rvalid;
                chk($sformatf("R_rvalid%0d", i), 32'(rv[i]), 32'(erv));
                if (erv) chk($sformatf("R_rdata%0d", i), s_rdata[i] ^ 32'(s_rresp[i]), m_rdata ^ 32'(m_rresp));
            end
            chk("R_m_rready", 32'(m_rready), 32'(rbusy && rsent && r_rdy[rown]));
            if (exp2 != 2'b00) begin
                rbusy = 1; rown = rw; raddr_exp = ar_a[rw]; rsent = 0; rlast = rw; ar_take[rw] = 1'b1;
            end else if (rbusy && !rsent) begin
                if (m_arready) begin rsent = 1; s_rpend = 1; s_rdly = $urandom_range(0, 3); end
            end else if (rbusy && m_rvalid && r_rdy[rown]) begin
                rbusy = 0; r_drop = 1; rcnt++;
            end
            // write path expectations
            expw = '0; ww = 0;
            if (!wbusy && (aw_v & w_v) != 2'b00) begin
                ww = pick(aw_v & w_v, wlast);
                expw = (ww == 1) ? 2'b10 : 2'b01;
            end
            chk("W_awready", 32'(awr), 32'(expw));
            chk("W_wready", 32'(wr), 32'(expw));
            chk("W_wr_grant", 32'(wr_grant), wbusy ? ((wown == 1) ? 32'd2 : 32'd1) : 32'd0);
            chk("W_m_awvalid", 32'(m_awvalid), 32'(wbusy && !aw_sent));
            chk("W_m_wvalid", 32'(m_wvalid), 32'(wbusy && !w_sent));
            if (wbusy && !aw_sent) chk("W_m_awaddr", m_awaddr, waddr_exp);
            if (wbusy && !w_sent) chk("W_m_wdata", m_wdata ^ {28'd0, m_wstrb}, wdata_exp ^ {28'd0, wstrb_exp});
            for (int i = 0; i < 2; i++) begin
                ebv = wbusy && aw_sent && w_sent && (wown == i) && m_bvalid;
                chk($sformatf("W_bvalid%0d", i), 32'(bv[i]), 32'(ebv));
                if (ebv) chk($sformatf("W_bresp%0d", i), 32'(s_bresp[i]), 32'(m_bresp));
            end
            chk("W_m_bready", 32'(m_bready), 32'(wbusy && aw_sent && w_sent && b_rdy[wown]));
            if (expw != 2'b00) begin
                wbusy = 1; wown = ww; waddr_exp = aw_a[ww]; wdata_exp = w_d[ww]; wstrb_exp = w_s[ww];
                aw_sent = 0; w_sent = 0; wlast = ww; aw_take[ww] = 1'b1;
            end else if (wbusy && !(aw_sent && w_sent)) begin
                if (!aw_sent && m_awready) aw_sent = 1;
                if (!w_sent && m_wready) w_sent = 1;
                if (aw_sent && w_sent) begin s_bpend = 1; s_bdly = $urandom_range(0, 3); end
            end else if (wbusy && m_bvalid && b_rdy[wown]) begin
                wbusy = 0; b_drop = 1; wcnt++;
            end
        end
        chk("R_progress", 32'(rcnt > 50), 32'd1);
        chk("W_progress", 32'(wcnt > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
